// File: rtl/pred_enc_pkg.sv
// Shared types and encodings for the encoder-side prediction mode decider.
// The mode encodings match the ones the decoder's prediction stage consumes.
package pred_enc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Candidate kinds in evaluation order; the intra kinds share their value
  // with the decoder's intra_mode code.
  typedef enum logic [1:0] {
    CAND_DC    = 2'd0,
    CAND_VER   = 2'd1,
    CAND_HOR   = 2'd2,
    CAND_INTER = 2'd3
  } cand_t;

  localparam logic [7:0] PRED_INTRA = 8'd0;
  localparam logic [7:0] PRED_INTER = 8'd1;

  localparam logic [7:0] INTRA_DC  = 8'd0;
  localparam logic [7:0] INTRA_VER = 8'd1;
  localparam logic [7:0] INTRA_HOR = 8'd2;

  // Accumulator / best_sad width; 255*BLOCK_SIZE^2 fits for BLOCK_SIZE <= 16.
  localparam int SAD_W = 16;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // intra_mode value reported for a winning candidate (0 for inter).
  function automatic logic [7:0] intra_code(input cand_t c);
    case (c)
      CAND_VER: return INTRA_VER;
      CAND_HOR: return INTRA_HOR;
      default:  return INTRA_DC;
    endcase
  endfunction

endpackage

// File: rtl/prediction_mode_decider_if.sv
// Request/result bundle of the prediction mode decider.
// Handshake: start is a request that the decider takes only while idle; busy
// stays high from that acceptance until the result handshake. valid_out
// holds the result and all result fields stable until a cycle in which
// out_ready is high; that edge completes the transfer.
interface prediction_mode_decider_if #(
  parameter int BLOCK_SIZE   = 8,
  parameter int SEARCH_RANGE = 1
);
  localparam int W = BLOCK_SIZE + 2 * SEARCH_RANGE;

  logic                                      start;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][7:0] orig_block;  // [y][x]
  logic [BLOCK_SIZE-1:0][7:0]                top_pixels;
  logic [BLOCK_SIZE-1:0][7:0]                left_pixels;
  logic                                      top_available;
  logic                                      left_available;
  logic [W-1:0][W-1:0][7:0]                  ref_window;  // [y][x]
  logic                                      busy;
  logic                                      valid_out;
  logic                                      out_ready;
  logic [7:0]                                pred_mode;
  logic [7:0]                                intra_mode;
  logic signed [8:0]                         mv_x;
  logic signed [8:0]                         mv_y;
  logic [15:0]                               best_sad;

  modport master (
    output start, orig_block, top_pixels, left_pixels, top_available,
           left_available, ref_window, out_ready,
    input  busy, valid_out, pred_mode, intra_mode, mv_x, mv_y, best_sad
  );

  modport slave (
    input  start, orig_block, top_pixels, left_pixels, top_available,
           left_available, ref_window, out_ready,
    output busy, valid_out, pred_mode, intra_mode, mv_x, mv_y, best_sad
  );
endinterface

// File: rtl/row_sad_unit.sv
// Combinational SAD of one block row against one predicted row.
module row_sad_unit
  import pred_enc_pkg::*;
#(
  parameter int BLOCK_SIZE = 8
) (
  input  logic [BLOCK_SIZE-1:0][7:0]         orig_row,
  input  logic [BLOCK_SIZE-1:0][7:0]         pred_row,
  output logic [8+$clog2(BLOCK_SIZE)-1:0]    row_sad
);
  localparam int IDX_W     = $clog2(BLOCK_SIZE);
  localparam int ROW_SAD_W = 8 + IDX_W;

  // Sum of per-pixel absolute differences across the row.
  always_comb begin
    row_sad = '0;
    for (int x = 0; x < BLOCK_SIZE; x++) begin
      row_sad = row_sad + ROW_SAD_W'(abs_diff(orig_row[IDX_W'(x)], pred_row[IDX_W'(x)]));
    end
  end
endmodule

// File: rtl/prediction_mode_decider.sv
// Picks the cheapest of DC/vertical/horizontal intra and integer-MV inter
// candidates by SAD, evaluating one block row per clock.
module prediction_mode_decider
  import pred_enc_pkg::*;
#(
  parameter int BLOCK_SIZE   = 8,
  parameter int SEARCH_RANGE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  prediction_mode_decider_if.slave  bus,
  output state_t                    state_dbg
);
  localparam int W         = BLOCK_SIZE + 2 * SEARCH_RANGE;
  localparam int ROW_W     = $clog2(BLOCK_SIZE);
  localparam int WIN_W     = $clog2(W);
  localparam int OFF_W     = $clog2(2 * SEARCH_RANGE + 2);
  localparam int ROW_SAD_W = 8 + ROW_W;
  localparam logic [OFF_W-1:0]   OFF_MAX   = OFF_W'(2 * SEARCH_RANGE);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(BLOCK_SIZE - 1);
  localparam logic signed [8:0]  MV_BIAS   = 9'(SEARCH_RANGE);

  state_t                                    state_q;
  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][7:0] orig_q;
  logic [BLOCK_SIZE-1:0][7:0]                top_q;
  logic [BLOCK_SIZE-1:0][7:0]                left_q;
  logic                                      top_av_q;
  logic                                      left_av_q;
  logic [W-1:0][W-1:0][7:0]                  ref_q;
  logic [7:0]                                dc_q;

  // Current candidate; inter MVs are held as offsets 0..2R (mv + R).
  cand_t                                     cand_q;
  logic [OFF_W-1:0]                          offx_q;
  logic [OFF_W-1:0]                          offy_q;
  logic [ROW_W-1:0]                          row_q;
  logic [SAD_W-1:0]                          acc_q;

  cand_t                                     best_cand_q;
  logic [OFF_W-1:0]                          best_offx_q;
  logic [OFF_W-1:0]                          best_offy_q;
  logic [SAD_W-1:0]                          best_sad_q;

  logic                                      busy_q;
  logic                                      valid_q;
  logic [7:0]                                pred_mode_q;
  logic [7:0]                                intra_mode_q;
  logic signed [8:0]                         mv_x_q;
  logic signed [8:0]                         mv_y_q;
  logic [SAD_W-1:0]                          out_sad_q;

  logic [SAD_W-1:0]                          sum_top;
  logic [SAD_W-1:0]                          sum_left;
  logic [SAD_W-1:0]                          dc_wide;
  logic [BLOCK_SIZE-1:0][7:0]                pred_row;
  logic [WIN_W-1:0]                          ref_y;
  logic [ROW_SAD_W-1:0]                      row_sad;
  logic [SAD_W-1:0]                          total;
  logic                                      improve;
  logic                                      last_row;
  cand_t                                     next_cand;
  logic [OFF_W-1:0]                          next_offx;
  logic [OFF_W-1:0]                          next_offy;
  logic                                      last_cand;
  cand_t                                     fin_cand;
  logic [OFF_W-1:0]                          fin_offx;
  logic [OFF_W-1:0]                          fin_offy;
  logic [SAD_W-1:0]                          fin_sad;

  assign state_dbg      = state_q;
  assign bus.busy       = busy_q;
  assign bus.valid_out  = valid_q;
  assign bus.pred_mode  = pred_mode_q;
  assign bus.intra_mode = intra_mode_q;
  assign bus.mv_x       = mv_x_q;
  assign bus.mv_y       = mv_y_q;
  assign bus.best_sad   = out_sad_q;

  // DC predictor from the registered neighbours, with rounding.
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int x = 0; x < BLOCK_SIZE; x++) begin
      sum_top  = sum_top + SAD_W'(top_q[ROW_W'(x)]);
      sum_left = sum_left + SAD_W'(left_q[ROW_W'(x)]);
    end
    if (top_av_q && left_av_q)
      dc_wide = (sum_top + sum_left + SAD_W'(BLOCK_SIZE)) >> (ROW_W + 1);
    else if (top_av_q)
      dc_wide = (sum_top + SAD_W'(BLOCK_SIZE / 2)) >> ROW_W;
    else if (left_av_q)
      dc_wide = (sum_left + SAD_W'(BLOCK_SIZE / 2)) >> ROW_W;
    else
      dc_wide = SAD_W'(128);
  end

  // Predicted pixels of the current row for the current candidate.
  always_comb begin
    pred_row = '0;
    ref_y    = WIN_W'(row_q) + WIN_W'(offy_q);
    for (int x = 0; x < BLOCK_SIZE; x++) begin
      case (cand_q)
        CAND_DC:  pred_row[ROW_W'(x)] = dc_q;
        CAND_VER: pred_row[ROW_W'(x)] = top_q[ROW_W'(x)];
        CAND_HOR: pred_row[ROW_W'(x)] = left_q[row_q];
        default:  pred_row[ROW_W'(x)] = ref_q[ref_y][WIN_W'(x) + WIN_W'(offx_q)];
      endcase
    end
  end

  row_sad_unit #(
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_row_sad (
    .orig_row (orig_q[row_q]),
    .pred_row (pred_row),
    .row_sad  (row_sad)
  );

  assign total    = acc_q + SAD_W'(row_sad);
  assign improve  = (total < best_sad_q);
  assign last_row = (row_q == ROW_LAST);

  // Successor in the fixed candidate order, skipping unavailable intra modes.
  always_comb begin
    next_cand = CAND_INTER;
    next_offx = '0;
    next_offy = '0;
    last_cand = 1'b0;
    case (cand_q)
      CAND_DC: begin
        if (top_av_q)       next_cand = CAND_VER;
        else if (left_av_q) next_cand = CAND_HOR;
      end
      CAND_VER: begin
        if (left_av_q) next_cand = CAND_HOR;
      end
      CAND_HOR: begin
        next_cand = CAND_INTER;
      end
      default: begin
        if (offx_q != OFF_MAX) begin
          next_offx = offx_q + 1'b1;
          next_offy = offy_q;
        end else if (offy_q != OFF_MAX) begin
          next_offy = offy_q + 1'b1;
        end else begin
          next_offx = offx_q;
          next_offy = offy_q;
          last_cand = 1'b1;
        end
      end
    endcase
  end

  // Winner including the candidate finishing this cycle (strictly smaller wins).
  always_comb begin
    fin_cand = improve ? cand_q : best_cand_q;
    fin_offx = improve ? offx_q : best_offx_q;
    fin_offy = improve ? offy_q : best_offy_q;
    fin_sad  = improve ? total  : best_sad_q;
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      orig_q       <= '0;
      top_q        <= '0;
      left_q       <= '0;
      top_av_q     <= 1'b0;
      left_av_q    <= 1'b0;
      ref_q        <= '0;
      dc_q         <= '0;
      cand_q       <= CAND_DC;
      offx_q       <= '0;
      offy_q       <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      best_cand_q  <= CAND_DC;
      best_offx_q  <= '0;
      best_offy_q  <= '0;
      best_sad_q   <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      pred_mode_q  <= '0;
      intra_mode_q <= '0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      out_sad_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            orig_q    <= bus.orig_block;
            top_q     <= bus.top_pixels;
            left_q    <= bus.left_pixels;
            top_av_q  <= bus.top_available;
            left_av_q <= bus.left_available;
            ref_q     <= bus.ref_window;
            busy_q    <= 1'b1;
            state_q   <= S_PREP;
          end
        end
        S_PREP: begin
          dc_q       <= dc_wide[7:0];
          best_sad_q <= '1;
          acc_q      <= '0;
          row_q      <= '0;
          cand_q     <= CAND_DC;
          offx_q     <= '0;
          offy_q     <= '0;
          state_q    <= S_EVAL;
        end
        S_EVAL: begin
          if (!last_row) begin
            acc_q <= total;
            row_q <= row_q + 1'b1;
          end else begin
            acc_q <= '0;
            row_q <= '0;
            if (improve) begin
              best_sad_q  <= total;
              best_cand_q <= cand_q;
              best_offx_q <= offx_q;
              best_offy_q <= offy_q;
            end
            if (last_cand) begin
              valid_q      <= 1'b1;
              pred_mode_q  <= (fin_cand == CAND_INTER) ? PRED_INTER : PRED_INTRA;
              intra_mode_q <= intra_code(fin_cand);
              mv_x_q       <= (fin_cand == CAND_INTER) ? ($signed(9'(fin_offx)) - MV_BIAS) : '0;
              mv_y_q       <= (fin_cand == CAND_INTER) ? ($signed(9'(fin_offy)) - MV_BIAS) : '0;
              out_sad_q    <= fin_sad;
              state_q      <= S_DONE;
            end else begin
              cand_q <= next_cand;
              offx_q <= next_offx;
              offy_q <= next_offy;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prediction_mode_decider.sv
// Directed + randomized bench for prediction_mode_decider with a
// candidate-by-candidate SAD reference model.
module tb_prediction_mode_decider;
  import pred_enc_pkg::*;

  localparam int BS = 8;
  localparam int R  = 1;
  localparam int W  = BS + 2 * R;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  int checks = 0;
  int errors = 0;

  int orig [BS][BS];
  int top_px [BS];
  int left_px [BS];
  int refw [W][W];
  bit tav, lav;

  int e_pred, e_intra, e_mvx, e_mvy, e_sad, e_n;

  prediction_mode_decider_if #(.BLOCK_SIZE(BS), .SEARCH_RANGE(R)) bus ();

  prediction_mode_decider #(
    .BLOCK_SIZE   (BS),
    .SEARCH_RANGE (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cand_sad(int kind, int dc, int mvx, int mvy);
    int s = 0;
    int p;
    for (int y = 0; y < BS; y++) begin
      for (int x = 0; x < BS; x++) begin
        case (kind)
          0:       p = dc;
          1:       p = top_px[x];
          2:       p = left_px[y];
          default: p = refw[y + R + mvy][x + R + mvx];
        endcase
        s += (orig[y][x] > p) ? (orig[y][x] - p) : (p - orig[y][x]);
      end
    end
    return s;
  endfunction

  task automatic run_model();
    int st = 0;
    int sl = 0;
    int dc, s;
    for (int i = 0; i < BS; i++) begin
      st += top_px[i];
      sl += left_px[i];
    end
    if (tav && lav) dc = (st + sl + BS) / (2 * BS);
    else if (tav)   dc = (st + BS / 2) / BS;
    else if (lav)   dc = (sl + BS / 2) / BS;
    else            dc = 128;
    e_n = 1; e_pred = 0; e_intra = 0; e_mvx = 0; e_mvy = 0;
    e_sad = cand_sad(0, dc, 0, 0);
    if (tav) begin
      e_n++;
      s = cand_sad(1, dc, 0, 0);
      if (s < e_sad) begin e_sad = s; e_intra = 1; end
    end
    if (lav) begin
      e_n++;
      s = cand_sad(2, dc, 0, 0);
      if (s < e_sad) begin e_sad = s; e_intra = 2; end
    end
    for (int my = -R; my <= R; my++) begin
      for (int mx = -R; mx <= R; mx++) begin
        e_n++;
        s = cand_sad(3, dc, mx, my);
        if (s < e_sad) begin
          e_sad = s; e_pred = 1; e_intra = 0; e_mvx = mx; e_mvy = my;
        end
      end
    end
  endtask

  task automatic drive_inputs();
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        bus.orig_block[y][x] = 8'(orig[y][x]);
    for (int i = 0; i < BS; i++) begin
      bus.top_pixels[i]  = 8'(top_px[i]);
      bus.left_pixels[i] = 8'(left_px[i]);
    end
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        bus.ref_window[y][x] = 8'(refw[y][x]);
    bus.top_available  = tav;
    bus.left_available = lav;
  endtask

  // Garbage on the inputs after acceptance; the DUT must work from its copy.
  task automatic scramble_bus();
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        bus.orig_block[y][x] = 8'($urandom_range(255, 0));
    for (int i = 0; i < BS; i++) begin
      bus.top_pixels[i]  = 8'($urandom_range(255, 0));
      bus.left_pixels[i] = 8'($urandom_range(255, 0));
    end
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        bus.ref_window[y][x] = 8'($urandom_range(255, 0));
    bus.top_available  = 1'($urandom_range(1, 0));
    bus.left_available = 1'($urandom_range(1, 0));
  endtask

  task automatic fill_const(int ov, int nv, int rv, bit t, bit l);
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        orig[y][x] = ov;
    for (int i = 0; i < BS; i++) begin
      top_px[i] = nv;
      left_px[i] = nv;
    end
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        refw[y][x] = rv;
    tav = t;
    lav = l;
  endtask

  task automatic fill_rand(int lo, int hi);
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        orig[y][x] = int'($urandom_range(hi, lo));
    for (int i = 0; i < BS; i++) begin
      top_px[i] = int'($urandom_range(hi, lo));
      left_px[i] = int'($urandom_range(hi, lo));
    end
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        refw[y][x] = int'($urandom_range(hi, lo));
    tav = 1'($urandom_range(1, 0));
    lav = 1'($urandom_range(1, 0));
  endtask

  // Start a request and wait (bounded) for valid_out; lat = edges after acceptance.
  task automatic accept_and_wait(input string tag, output int lat);
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    scramble_bus();
    chk({tag, ":busy_after_accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 4000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":valid"},      32'(bus.valid_out),  32'd1);
    chk({tag, ":pred_mode"},  32'(bus.pred_mode),  32'(e_pred));
    chk({tag, ":intra_mode"}, 32'(bus.intra_mode), 32'(e_intra));
    chk({tag, ":mv_x"},       32'(bus.mv_x),       32'(e_mvx));
    chk({tag, ":mv_y"},       32'(bus.mv_y),       32'(e_mvy));
    chk({tag, ":best_sad"},   32'(bus.best_sad),   32'(e_sad));
    chk({tag, ":state"},      32'(state_dbg),      32'(S_DONE));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ":busy_after_hs"},  32'(bus.busy),      32'd0);
    chk({tag, ":valid_after_hs"}, 32'(bus.valid_out), 32'd0);
    chk({tag, ":idle_after_hs"},  32'(state_dbg),     32'(S_IDLE));
  endtask

  task automatic run_case(input string tag);
    int lat;
    run_model();
    accept_and_wait(tag, lat);
    chk({tag, ":latency"}, 32'(lat), 32'(1 + e_n * BS));
    check_outputs(tag);
    handshake(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ":pred_mode"},  32'(bus.pred_mode),  32'd0);
    chk({tag, ":intra_mode"}, 32'(bus.intra_mode), 32'd0);
    chk({tag, ":mv_x"},       32'(bus.mv_x),       32'd0);
    chk({tag, ":mv_y"},       32'(bus.mv_y),       32'd0);
    chk({tag, ":best_sad"},   32'(bus.best_sad),   32'd0);
    chk({tag, ":busy"},       32'(bus.busy),       32'd0);
    chk({tag, ":valid"},      32'(bus.valid_out),  32'd0);
    chk({tag, ":state"},      32'(state_dbg),      32'(S_IDLE));
  endtask

  initial begin
    int lat;

    // Reset
    reset = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    fill_const(0, 0, 0, 1'b0, 1'b0);
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Flat block: DC matches exactly, N=12, latency 97
    fill_const(100, 100, 0, 1'b1, 1'b1);
    run_case("flat");

    // Inter match at mv (+1,-1)
    fill_const(0, 0, 0, 1'b1, 1'b1);
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        refw[y][x] = int'($urandom_range(255, 1));
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        orig[y][x] = refw[y][x + 2];
    run_case("inter_match");

    // No neighbours: DC defaults to 128, N=10
    fill_const(128, 0, 0, 1'b0, 1'b0);
    run_case("no_neigh");

    // Everything equal: earliest candidate (DC) wins the tie
    fill_const(50, 50, 50, 1'b1, 1'b1);
    run_case("tie");

    // Random blocks, narrow range to provoke ties, wide range for spread
    for (int k = 0; k < 3; k++) begin
      fill_rand(0, 3);
      run_case("rand_narrow");
    end
    for (int k = 0; k < 3; k++) begin
      fill_rand(0, 255);
      run_case("rand_wide");
    end

    // Backpressure with start pulses in DONE
    fill_rand(0, 255);
    run_model();
    accept_and_wait("bp", lat);
    chk("bp:latency", 32'(lat), 32'(1 + e_n * BS));
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'(i % 2);
      @(posedge clk);
      @(negedge clk);
      check_outputs("bp_hold");
    end
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp:busy_after_hs",  32'(bus.busy),      32'd0);
    chk("bp:valid_after_hs", 32'(bus.valid_out), 32'd0);
    chk("bp:idle_after_hs",  32'(state_dbg),     32'(S_IDLE));
    @(posedge clk);
    @(negedge clk);
    chk("bp:start_ignored", 32'(state_dbg), 32'(S_IDLE));
    fill_rand(0, 255);
    run_case("after_bp");

    // Reset in the middle of EVAL
    fill_rand(20, 200);
    run_model();
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset:in_eval", 32'(state_dbg), 32'(S_EVAL));
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    run_case("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
